// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary ROWSxCOLS matmul tile with input skew, flush and row-wise drain.
// Define SYSTOLIC_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise sums wrap and ovf is 0.
module systolic_array_os #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 256,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    output logic                     busy,
    output logic                     done,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [COLS*DATA_W-1:0]   b_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic [COLS*ACC_W-1:0]    c_data,
    output logic [$clog2(ROWS)-1:0]  c_row,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     c_last,
    output logic                     ovf
);
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
    localparam int F  = ROWS + COLS - 1;
    localparam int FW = $clog2(F + 1);
    localparam int RW = $clog2(ROWS);
    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d, beat_q, beat_d, k_eff;
    logic [FW-1:0] fl_q, fl_d;
    logic [RW-1:0] row_q, row_d;
    logic done_q, done_d;
    logic fire, adv, clr;
    // Operands carry their valid tag in the MSB.
    logic [DATA_W:0] a_in [ROWS];
    logic [DATA_W:0] b_in [COLS];
    logic [DATA_W:0] a_op [ROWS][COLS];
    logic [DATA_W:0] b_op [ROWS][COLS];
    logic [ACC_W-1:0] acc [ROWS][COLS];

    assign k_eff = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign fire  = a_valid && b_valid && state_q == FEED;
    assign adv   = fire || state_q == FLUSH;
    assign clr   = start && state_q == IDLE;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        fl_d    = fl_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                k_d     = k_eff;
                beat_d  = '0;
                fl_d    = '0;
                row_d   = '0;
                state_d = (k_eff == '0) ? DRAIN : FEED;
            end
            FEED: if (fire) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == k_q - 1'b1) state_d = FLUSH;
            end
            FLUSH: begin
                fl_d = fl_q + 1'b1;
                if (fl_q == FW'(F - 1)) state_d = DRAIN;
            end
            DRAIN: if (c_ready) begin
                row_d = c_last ? '0 : row_q + 1'b1;
                state_d = c_last ? IDLE : DRAIN;
                done_d  = c_last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            fl_q    <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign a_ready = state_q == FEED && b_valid;
    assign b_ready = state_q == FEED && a_valid;
    assign c_valid = state_q == DRAIN;
    assign c_last  = c_valid && row_q == RW'(ROWS - 1);
    assign c_row   = row_q;

    genvar r, c;
    // Row r of A is delayed r advances before entering column 0.
    for (r = 0; r < ROWS; r++) begin : g_row
        assign a_in[r] = fire ? {1'b1, a_data[r*DATA_W +: DATA_W]} : '0;
        if (r == 0) begin : g_direct
            assign a_op[r][0] = a_in[r];
        end else begin : g_skew
            logic [DATA_W:0] sk_q [r];
            logic [DATA_W:0] sk_d [r];
            always_comb begin
                sk_d[0] = adv ? a_in[r] : sk_q[0];
                for (int i = 1; i < r; i++) sk_d[i] = adv ? sk_q[i-1] : sk_q[i];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sk_q <= '{default: '0};
                else        sk_q <= sk_d;
            end
            assign a_op[r][0] = sk_q[r-1];
        end
    end

    for (c = 0; c < COLS; c++) begin : g_col
        assign b_in[c] = fire ? {1'b1, b_data[c*DATA_W +: DATA_W]} : '0;
        if (c == 0) begin : g_direct
            assign b_op[0][c] = b_in[c];
        end else begin : g_skew
            logic [DATA_W:0] sk_q [c];
            logic [DATA_W:0] sk_d [c];
            always_comb begin
                sk_d[0] = adv ? b_in[c] : sk_q[0];
                for (int i = 1; i < c; i++) sk_d[i] = adv ? sk_q[i-1] : sk_q[i];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sk_q <= '{default: '0};
                else        sk_q <= sk_d;
            end
            assign b_op[0][c] = sk_q[c-1];
        end
        assign c_data[c*ACC_W +: ACC_W] = acc[row_q][c];
    end

`ifdef SYSTOLIC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ROWS*COLS-1:0] sat;
    logic ovf_q, ovf_d;
    assign ovf_d = clr ? 1'b0 : ovf_q | (|sat);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    for (r = 0; r < ROWS; r++) begin : g_pe_r
        for (c = 0; c < COLS; c++) begin : g_pe_c
            logic [ACC_W-1:0] acc_q, acc_d;
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0] prod_x;
            logic mac;
            assign mac    = adv && a_op[r][c][DATA_W] && b_op[r][c][DATA_W];
            assign prod   = $signed(a_op[r][c][DATA_W-1:0]) * $signed(b_op[r][c][DATA_W-1:0]);
            assign prod_x = ACC_W'(prod);
            if (c < COLS - 1) begin : g_ah
                logic [DATA_W:0] ah_q, ah_d;
                assign ah_d = adv ? a_op[r][c] : ah_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) ah_q <= '0;
                    else        ah_q <= ah_d;
                end
                assign a_op[r][c+1] = ah_q;
            end
            if (r < ROWS - 1) begin : g_bh
                logic [DATA_W:0] bh_q, bh_d;
                assign bh_d = adv ? b_op[r][c] : bh_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) bh_q <= '0;
                    else        bh_q <= bh_d;
                end
                assign b_op[r+1][c] = bh_q;
            end
`ifdef SYSTOLIC_SAT_EN
            logic [ACC_W:0] sum;
            logic clip;
            assign sum  = {acc_q[ACC_W-1], acc_q} + {prod_x[ACC_W-1], prod_x};
            assign clip = sum[ACC_W] != sum[ACC_W-1];
            assign sat[r*COLS+c] = mac && clip;
            always_comb acc_d = clr ? '0 : !mac ? acc_q : !clip ? sum[ACC_W-1:0] : sum[ACC_W] ? ACC_MIN : ACC_MAX;
`else
            always_comb acc_d = clr ? '0 : mac ? acc_q + prod_x : acc_q;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else        acc_q <= acc_d;
            end
            assign acc[r][c] = acc_q;
        end
    end
endmodule

// File: doc/systolic_array_os.md
# systolic_array_os

Parametrised output-stationary systolic matrix-multiply tile. It computes C[ROWS×COLS] = A[ROWS×K] · B[K×COLS] for a runtime inner dimension K. The block includes internal input skewing, a stall-capable feed pipeline, and explicit flush/drain sequencing. Results leave the block row by row over a ready/valid stream. It is the next-generation replacement for the fixed-size always-ready array, and sits between the operand fetch buffers and the result writeback path.

## Interface
- ROWS, default 8: PE rows; number of A elements per beat.
- COLS, default 8: PE columns; number of B elements per beat.
- DATA_W, default 16: signed operand width.
- ACC_W, default 32: signed accumulator width; must satisfy ACC_W ≥ 2·DATA_W.
- K_MAX, default 256: maximum inner dimension.
- KW, default $clog2(K_MAX+1): width of k_len.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin operation; honoured only in IDLE.
- k_len  in  KW  inner dimension; sampled with start; 0..K_MAX.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the last result row handshake.
- a_data  in  ROWS·DATA_W  one column of A; element r in bits [r·DATA_W +: DATA_W].
- a_valid  in  1  A beat valid.
- a_ready  out  1  = (state==FEED) && b_valid.
- b_data  in  COLS·DATA_W  one row of B; element c in bits [c·DATA_W +: DATA_W].
- b_valid  in  1  B beat valid.
- b_ready  out  1  = (state==FEED) && a_valid.
- c_data  out  COLS·ACC_W  one result row; column c in bits [c·ACC_W +: ACC_W].
- c_row  out  $clog2(ROWS)  index of the row on c_data.
- c_valid  out  1  result row valid.
- c_ready  in  1  downstream accepts the row.
- c_last  out  1  high with the final row (c_row==ROWS-1).
- ovf  out  1  sticky accumulator-overflow flag; cleared by start.

## Operation
- States: IDLE, FEED, FLUSH, DRAIN.
- Transitions:
  - IDLE→FEED on start with k_len>0. This clears all accumulators and ovf, latches k_len, and zeros the beat counter.
  - IDLE→DRAIN on start with k_len==0. Accumulators are cleared, so every output row is zeros.
  - FEED→FLUSH on the fire cycle of beat k_len-1.
  - FLUSH→DRAIN after F = ROWS+COLS-1 cycles.
  - DRAIN→IDLE on the c_valid&&c_ready handshake with c_last.
- Beat fire = a_valid && b_valid && state==FEED. A and B are consumed jointly, one beat per fire.
- Array advance enable adv = fire || state==FLUSH. With adv low, all skew registers, operand pipes and valid tags hold.
- Skew: A element r is delayed r advances; B element c is delayed c advances. Each operand carries a valid tag. Beat k reaches PE(r,c) after r+c advances. FLUSH injects zero data with tag 0.
- PE(r,c): when adv and both tags are set, acc += sext(a·b). Otherwise acc holds.
- Arithmetic: the product is signed 2·DATA_W, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W unless SYSTOLIC_SAT_EN is defined.
- DRAIN presents rows 0..ROWS-1 in order and advances on each handshake. c_data, c_row and c_last stay stable while c_valid && !c_ready.
- start outside IDLE is ignored, and k_len changes outside the start cycle are ignored. k_len > K_MAX is clamped to K_MAX.

## Timing
- Reset values: state=IDLE; busy, done, a_ready, b_ready, c_valid, c_last, ovf = 0; c_data = 0; c_row = 0; all accumulators and pipes 0.
- start in cycle t → busy, and a_ready/b_ready if the peer is valid, from t+1.
- Throughput: 1 beat/cycle in FEED; 1 row/cycle in DRAIN with c_ready held high.
- Last beat fires in cycle T → FLUSH spans T+1..T+F → c_valid first high at T+F+1.
- With c_ready held, rows appear at T+F+1 … T+F+ROWS, and done pulses at T+F+ROWS+1 with busy low in the same cycle.
- k_len==0: start at t → c_valid at t+1.
- Reset asserted mid-operation: returns to IDLE immediately (asynchronous); accumulators cleared; no done pulse.

## Configuration
- SYSTOLIC_SAT_EN defined: accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamping event sets ovf until the next start.
- Undefined: accumulation wraps two's-complement and ovf is tied 0. Ports are identical in both builds.

## Test plan
- ROWS=COLS=4, k_len=4, A=identity, B rows {1..4},{5..8},{9..12},{13..16}, c_ready=1 → rows equal B, c_row 0..3, c_last on row 3. First c_valid 8 cycles after the last beat; done one cycle after row 3.
- Same operands, a_valid/b_valid randomly deasserted ~50% → identical C; no beat lost or duplicated; a_ready low whenever b_valid is low.
- Same operands, c_ready toggled 1-0-0-1 → each row held stable while stalled; exactly 4 handshakes; done after the 4th.
- k_len=0 → four zero rows starting the cycle after start; ovf=0.
- DATA_W=16, ACC_W=32, all a=b=-32768, k_len=4 → every C element 0 without the macro. With SYSTOLIC_SAT_EN, every element is 2147483647 and ovf=1.
- start pulsed during FEED → ignored. rst_n low mid-FEED, then a new run with k_len=2 → results reflect only the new operands.
